voting_session: RTL and testbench

Sequential, parametrised successor to the 5-input combinational majority voter. Runs a voting session for N_VOTERS voters:
- opens on a start pulse;
- accepts one vote per voter;
- keeps running yes/no tallies;
- closes early once the outcome is fixed, when all have voted, or on timeout;
- latches the pass/fail result.

It sits between the debounced switch/button front-end and the LED/segment display logic.

---
 rtl/voting_pkg.sv | 33 +++
 rtl/voting_popcount.sv | 19 +
 rtl/voting_session.sv | 117 +++++++++++
 tb/tb_voting_session.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voting_pkg.sv
// Shared definitions for the voting session block:
// state encoding, clog2 helper and parameter legality check.
`ifndef VOTING_PKG_SV
`define VOTING_PKG_SV

`define VOTING_CHECK_PARAMS(n, t, to) \
  if ((n) < 1 || (n) > 32 || (t) < 1 || (t) > (n) || (to) < 1) begin : g_bad_params \
    $error("voting_session: illegal parameter set"); \
  end

package voting_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OPEN   = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_OPEN   = ST_OPEN,
    S_RESULT = ST_RESULT
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

`endif

// File: rtl/voting_popcount.sv
// Combinational population count of a W-bit mask.
module voting_popcount
  import voting_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0]              bits,
  output logic [clog2(W+1)-1:0]     count
);

  localparam int CW = clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++)
      count = count + CW'(bits[i]);
  end

endmodule

// File: rtl/voting_session.sv
// Sequential voting session: one vote per voter, early close
// on a decided outcome, full turnout or timeout; latched result.
module voting_session
  import voting_pkg::*;
#(
  parameter int N_VOTERS    = 5,
  parameter int THRESHOLD   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N_VOTERS-1:0]           vote_valid,
  input  logic [N_VOTERS-1:0]           vote_val,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [clog2(N_VOTERS+1)-1:0]  yes_cnt,
  output logic [clog2(N_VOTERS+1)-1:0]  no_cnt,
  output logic [N_VOTERS-1:0]           voted
);

  localparam int CNT_W = clog2(N_VOTERS + 1);
  localparam int TMR_W = clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] NO_LIM = CNT_W'(N_VOTERS - THRESHOLD);
  localparam logic [TMR_W-1:0] T_LAST = TMR_W'(TIMEOUT_CYC - 1);

  `VOTING_CHECK_PARAMS(N_VOTERS, THRESHOLD, TIMEOUT_CYC)

  state_t state, state_nxt;

  logic [TMR_W-1:0]    timer;
  logic [N_VOTERS-1:0] elig;
  logic [CNT_W-1:0]    yes_add, no_add;
  logic [CNT_W-1:0]    yes_nxt, no_nxt;
  logic                cl_yes, cl_no, cl_all, cl_tmo, close;

  assign elig = vote_valid & ~voted;

  voting_popcount #(.W(N_VOTERS)) u_pc_yes (
    .bits  (elig & vote_val),
    .count (yes_add)
  );

  voting_popcount #(.W(N_VOTERS)) u_pc_no (
    .bits  (elig & ~vote_val),
    .count (no_add)
  );

  // Tallies are bounded by N_VOTERS, so CNT_W never wraps.
  assign yes_nxt = yes_cnt + yes_add;
  assign no_nxt  = no_cnt + no_add;

  assign cl_yes = yes_nxt >= THR;
  assign cl_no  = no_nxt > NO_LIM;
  assign cl_all = &(voted | elig);
  assign cl_tmo = timer == T_LAST;
  assign close  = cl_yes | cl_no | cl_all | cl_tmo;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (1'b1)
      state == S_IDLE: begin
        if (start) state_nxt = S_OPEN;
      end
      state == S_OPEN: begin
        busy = 1'b1;
        if (close) state_nxt = S_RESULT;
      end
      state == S_RESULT: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass    <= 1'b0;
      timeout <= 1'b0;
      yes_cnt <= '0;
      no_cnt  <= '0;
      voted   <= '0;
      timer   <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        pass    <= 1'b0;
        timeout <= 1'b0;
        yes_cnt <= '0;
        no_cnt  <= '0;
        voted   <= '0;
        timer   <= '0;
      end else if (state == S_OPEN) begin
        voted   <= voted | elig;
        yes_cnt <= yes_nxt;
        no_cnt  <= no_nxt;
        timer   <= timer + 1'b1;
        if (close) begin
          pass    <= cl_yes;
          timeout <= cl_tmo & ~cl_yes & ~cl_no & ~cl_all;
        end
      end
    end
  end

endmodule

// File: tb/tb_voting_session.sv
// Self-checking bench for voting_session (N=5, T=3, timeout 10)
// with directed scenarios and a randomized reference-model run.
module tb_voting_session;

  localparam int N  = 5;
  localparam int T  = 3;
  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] vote_valid;
  logic [N-1:0] vote_val;
  logic         busy, done, pass, timeout;
  logic [2:0]   yes_cnt, no_cnt;
  logic [N-1:0] voted;

  int errors = 0;
  int checks = 0;

  // Reference model: session phase, ballots cast and elapsed open cycles
  int     m_phase;
  int     m_yes, m_no, m_cycles;
  bit     m_cast [N];
  bit     m_pass, m_timeout;

  voting_session #(
    .N_VOTERS    (N),
    .THRESHOLD   (T),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vote_valid (vote_valid),
    .vote_val   (vote_val),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .yes_cnt    (yes_cnt),
    .no_cnt     (no_cnt),
    .voted      (voted)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] m_voted();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_cast[i];
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_yes = 0; m_no = 0; m_cycles = 0;
    m_pass = 0; m_timeout = 0;
    for (int i = 0; i < N; i++) m_cast[i] = 0;
  endtask

  task automatic step(input logic st, input logic [N-1:0] vv,
                      input logic [N-1:0] vl);
    bit decided, all_in, expired;
    int turnout;
    start = st; vote_valid = vv; vote_val = vl;
    @(posedge clk);
    if (m_phase == 0) begin
      if (st) begin
        model_reset();
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      for (int i = 0; i < N; i++)
        if (vv[i] && !m_cast[i]) begin
          m_cast[i] = 1;
          if (vl[i]) m_yes++; else m_no++;
        end
      turnout = 0;
      for (int i = 0; i < N; i++) turnout += m_cast[i];
      decided = (m_yes >= T) || (m_no > N - T);
      all_in  = turnout == N;
      expired = m_cycles == TO - 1;
      m_cycles++;
      if (decided || all_in || expired) begin
        m_pass    = m_yes >= T;
        m_timeout = !decided && !all_in;
        m_phase   = 2;
      end
    end else begin
      m_phase = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; vote_valid = '0; vote_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass, timeout, yes_cnt, no_cnt, voted} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %b required all zero",
               {busy, done, pass, timeout, yes_cnt, no_cnt, voted});
    end
    rst_n = 1;
    step(0, 5'b11111, 5'b11111);
    checks++;
    if (voted !== 5'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_votes_ignored: voted=%b busy=%b required 0 0",
               voted, busy);
    end
  endtask

  task automatic test_all_vote();
    step(1, 5'b00000, 5'b00000);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL open_busy: got %b required 1", busy);
    end
    step(0, 5'b11111, 5'b00111);
    checks++;
    if ({done, pass, timeout, busy} !== 4'b1100 || yes_cnt !== 3'd3 ||
        no_cnt !== 3'd2 || voted !== 5'b11111) begin
      errors++;
      $display("FAIL all_vote: d/p/t/b=%b y=%0d n=%0d v=%b required 1100 3 2 11111",
               {done, pass, timeout, busy}, yes_cnt, no_cnt, voted);
    end
    step(0, 5'b0, 5'b0);
    checks++;
    if (done !== 1'b0 || pass !== 1'b1 || yes_cnt !== 3'd3) begin
      errors++;
      $display("FAIL result_hold: done=%b pass=%b y=%0d required 0 1 3",
               done, pass, yes_cnt);
    end
  endtask

  task automatic test_early_pass();
    step(1, 5'b0, 5'b0);
    step(0, 5'b00001, 5'b11111);
    step(0, 5'b00010, 5'b11111);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || yes_cnt !== 3'd2) begin
      errors++;
      $display("FAIL early_mid: busy=%b done=%b y=%0d required 1 0 2",
               busy, done, yes_cnt);
    end
    step(0, 5'b00100, 5'b11111);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 ||
        voted !== 5'b00111 || no_cnt !== 3'd0) begin
      errors++;
      $display("FAIL early_pass: d=%b b=%b p=%b v=%b n=%0d required 1 0 1 00111 0",
               done, busy, pass, voted, no_cnt);
    end
    step(0, 5'b0, 5'b0);
  endtask

  task automatic test_duplicates();
    step(1, 5'b0, 5'b0);
    repeat (3) step(0, 5'b00001, 5'b00000 | 5'b00001);
    step(0, 5'b00010, 5'b00000);
    checks++;
    if (busy !== 1'b1 || yes_cnt !== 3'd1 || no_cnt !== 3'd1) begin
      errors++;
      $display("FAIL dup_mid: busy=%b y=%0d n=%0d required 1 1 1",
               busy, yes_cnt, no_cnt);
    end
    step(0, 5'b11100, 5'b00000);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || timeout !== 1'b0 ||
        yes_cnt !== 3'd1 || no_cnt !== 3'd4) begin
      errors++;
      $display("FAIL dup_close: d=%b p=%b t=%b y=%0d n=%0d required 1 0 0 1 4",
               done, pass, timeout, yes_cnt, no_cnt);
    end
    step(0, 5'b0, 5'b0);
  endtask

  task automatic test_timeout();
    step(1, 5'b0, 5'b0);
    for (int k = 1; k <= TO; k++) begin
      step(0, (k == 1) ? 5'b00001 : (k == 2) ? 5'b00010 : 5'b00000,
           5'b11111);
      if (k == TO - 1) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL tmo_early: done=%b busy=%b required 0 1", done, busy);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0 ||
        yes_cnt !== 3'd2 || no_cnt !== 3'd0) begin
      errors++;
      $display("FAIL timeout: d=%b t=%b p=%b y=%0d n=%0d required 1 1 0 2 0",
               done, timeout, pass, yes_cnt, no_cnt);
    end
    step(0, 5'b0, 5'b0);
  endtask

  task automatic test_start_ignored();
    step(1, 5'b0, 5'b0);
    step(1, 5'b00001, 5'b00001);
    step(1, 5'b00010, 5'b00000);
    checks++;
    if (busy !== 1'b1 || yes_cnt !== 3'd1 || no_cnt !== 3'd1) begin
      errors++;
      $display("FAIL start_busy: busy=%b y=%0d n=%0d required 1 1 1",
               busy, yes_cnt, no_cnt);
    end
    step(1, 5'b01100, 5'b01100);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || yes_cnt !== 3'd3) begin
      errors++;
      $display("FAIL start_close: d=%b p=%b y=%0d required 1 1 3",
               done, pass, yes_cnt);
    end
    step(0, 5'b0, 5'b0);
    step(1, 5'b0, 5'b0);
    checks++;
    if (busy !== 1'b1 || yes_cnt !== 3'd0 || no_cnt !== 3'd0 ||
        voted !== 5'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: b=%b y=%0d n=%0d v=%b p=%b required 1 0 0 0 0",
               busy, yes_cnt, no_cnt, voted, pass);
    end
    step(0, 5'b11111, 5'b00000);
    step(0, 5'b0, 5'b0);
  endtask

  task automatic test_reset_mid();
    step(1, 5'b0, 5'b0);
    step(0, 5'b00001, 5'b00001);
    step(0, 5'b00010, 5'b00000);
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({busy, done, pass, timeout, yes_cnt, no_cnt, voted} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %b required all zero",
               {busy, done, pass, timeout, yes_cnt, no_cnt, voted});
    end
    @(posedge clk);
    #1 rst_n = 1;
    step(0, 5'b11111, 5'b11111);
    checks++;
    if (voted !== 5'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: voted=%b busy=%b required 0 0", voted, busy);
    end
    step(1, 5'b0, 5'b0);
    step(0, 5'b11111, 5'b11000);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || yes_cnt !== 3'd2 ||
        no_cnt !== 3'd3) begin
      errors++;
      $display("FAIL reset_new: d=%b p=%b y=%0d n=%0d required 1 0 2 3",
               done, pass, yes_cnt, no_cnt);
    end
    step(0, 5'b0, 5'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] vv, vl;
    logic         st;
    int           n;
    for (int s = 0; s < 30; s++) begin
      n = 0;
      step(1, 5'b0, 5'b0);
      while (m_phase != 0 && n < 20) begin
        vv = N'($urandom) & N'($urandom);
        vl = N'($urandom);
        st = 1'($urandom);
        step(st, vv, vl);
        n++;
        checks++;
        if (busy !== (m_phase == 1) || done !== (m_phase == 2) ||
            pass !== m_pass || timeout !== m_timeout ||
            yes_cnt !== 3'(m_yes) || no_cnt !== 3'(m_no) ||
            voted !== m_voted()) begin
          errors++;
          $display("FAIL random s%0d c%0d: b%b d%b p%b t%b y%0d n%0d v%b required b%0d d%0d p%0d t%0d y%0d n%0d v%b",
                   s, n, busy, done, pass, timeout, yes_cnt, no_cnt, voted,
                   m_phase == 1, m_phase == 2, m_pass, m_timeout,
                   m_yes, m_no, m_voted());
        end
      end
      checks++;
      if (m_phase != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL random_close s%0d: busy=%b required 0", s, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_vote();
    test_early_pass();
    test_duplicates();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
